pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Consumes the hazard detection unit's data_hazard and PC_hazard outputs, plus PC-update, branch and halt events. Generates the per-stage hold, flush and bubble enables for the PC register, IF/ID register and ID/EX register. Sits between the hazard detection unit and the pipeline registers as the single owner of pipeline freeze policy. Adds bounded-stall supervision and a terminal halt state.

Parameters:
MAX_STALL, 3, maximum consecutive data-stall cycles before forced release (matches the 3 downstream writeback stages).
BR_FLUSH_CYC, 1, number of IF/ID flush cycles after a taken branch.
CNT_W, 3, width of the internal stall/flush counter; must satisfy 2^CNT_W > max(MAX_STALL, BR_FLUSH_CYC).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
data_hazard  in  1  RAW hazard from the hazard detection unit
PC_hazard  in  1  return in decode; PC target pending
PC_update  in  1  PC update logic has computed the new target this cycle
branch_taken  in  1  branch resolved taken this cycle
hlt  in  1  halt instruction decoded
PC_stall  out  1  hold PC register
IFID_stall  out  1  hold IF/ID register
IFID_flush  out  1  load NOP into IF/ID
IDEX_bubble  out  1  load NOP/zero control into ID/EX
halted  out  1  core halted (sticky until rst)
stall_timeout  out  1  sticky error: data stall reached MAX_STALL
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset: clk rising edge with rst=1 → state=RUN, cnt=0, stall_timeout=0. All outputs derived from RUN with inputs ignored read 0 during the reset cycle. rst mid-stall/halt aborts immediately.
- Outputs are combinational from {state, inputs} (Mealy), so a hazard stalls in the same cycle it is flagged. State and cnt are registered.
- Event priority within any non-HALT state: hlt > PC_update > PC_hazard > branch_taken > data_hazard.
- RUN:
  - hlt → PC_stall=IFID_stall=IDEX_bubble=1; next HALT.
  - PC_hazard → PC_stall=1, IFID_flush=1, IDEX_bubble=0; next PC_WAIT.
  - branch_taken → IFID_flush=1, IDEX_bubble=1.
    - BR_FLUSH_CYC=1: stay RUN.
    - BR_FLUSH_CYC>1: next BR_FLUSH, cnt=1.
  - data_hazard → PC_stall=IFID_stall=IDEX_bubble=1; next DSTALL, cnt=1.
  - Otherwise all 0.
- DSTALL:
  - data_hazard=1 and cnt<MAX_STALL → stall triple=1, cnt++.
  - data_hazard=1 and cnt==MAX_STALL → outputs 0 (forced release), stall_timeout←1, next RUN, cnt=0.
  - data_hazard=0 → outputs 0, next RUN, cnt=0.
- PC_WAIT:
  - PC_stall=1, IFID_flush=1, IDEX_bubble=1 each cycle until PC_update.
  - Cycle PC_update=1: PC_stall=0 (new target loads), IFID_flush=1, IDEX_bubble=1; next RUN.
  - PC_hazard is ignored while in PC_WAIT.
- BR_FLUSH: IFID_flush=1, IDEX_bubble=1, cnt++. When cnt==BR_FLUSH_CYC-1, next RUN, cnt=0.
- HALT: PC_stall=IFID_stall=IDEX_bubble=halted=1. All other inputs ignored; exit only via rst.
- Invariants:
  - IFID_stall and IFID_flush are never both 1.
  - X on data_hazard is treated as 0.
  - stall_timeout stays set until rst.
- cnt saturates and never wraps; width is checked by elaboration assertion.

Decomposition:
- Shared package hazard_pkg:
  - typedef enum logic [2:0] stall_state_t {RUN=0, DSTALL=1, PC_WAIT=2, BR_FLUSH=3, HALT=4}.
  - constant NOP_INSTR.
  - default MAX_STALL.
- One sub-module is natural: sat_counter (CNT_W-bit, sync clear, increment enable, saturate at max), used for cnt.

Test Plan:
- Reset: rst=1 for 2 cycles with data_hazard=1, hlt=1 → all outputs 0, state_dbg=0. Release → stall asserts in the same cycle.
- Data stall: data_hazard high 2 cycles then low → PC_stall/IFID_stall/IDEX_bubble=1 for exactly 2 cycles, then 0; stall_timeout=0.
- Timeout: data_hazard held 5 cycles with MAX_STALL=3 → stall triple=1 for cycles 1-3, 0 on cycle 4; stall_timeout=1 from cycle 5 until rst.
- Return: PC_hazard=1, PC_update after 4 cycles → PC_stall=1 for 4 cycles, 0 on the update cycle; IFID_flush=1 on all 5 cycles; state back to RUN.
- Priority: hlt and data_hazard and branch_taken asserted together → state HALT, halted=1; later PC_update pulses → outputs unchanged; rst → RUN.
- Branch with BR_FLUSH_CYC=2: branch_taken pulse → IFID_flush=1, IDEX_bubble=1 for 2 cycles; PC_stall=0 throughout.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for pipeline freeze control.
package hazard_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        DSTALL   = 3'd1,
        PC_WAIT  = 3'd2,
        BR_FLUSH = 3'd3,
        HALT     = 3'd4
    } stall_state_t;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam int          DEF_MAX_STALL = 3;

    // True when a counter of width w can hold both limits without wrapping.
    function automatic bit cnt_fits(input int w, input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ((1 << w) > m);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline freeze policy: per-stage hold/flush/bubble enables with bounded
// data-stall supervision and a terminal halt state.
//
// state    | meaning
// RUN      | normal issue, hazards evaluated each cycle
// DSTALL   | holding PC and IF/ID for a RAW hazard, bounded by MAX_STALL
// PC_WAIT  | return in decode, waiting for the new PC target
// BR_FLUSH | extra IF/ID flush cycles after a taken branch
// HALT     | core frozen until reset
module pipe_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_STALL    = DEF_MAX_STALL,
    parameter int BR_FLUSH_CYC = 1,
    parameter int CNT_W        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_hazard,
    input  logic       PC_hazard,
    input  logic       PC_update,
    input  logic       branch_taken,
    input  logic       hlt,
    output logic       PC_stall,
    output logic       IFID_stall,
    output logic       IFID_flush,
    output logic       IDEX_bubble,
    output logic       halted,
    output logic       stall_timeout,
    output logic [2:0] state_dbg
);

    if (!cnt_fits(CNT_W, MAX_STALL, BR_FLUSH_CYC)) begin : g_cnt_w_check
        $error("CNT_W too narrow for MAX_STALL/BR_FLUSH_CYC");
    end

    stall_state_t     state_q, state_d;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr, cnt_inc, timeout_set;
    logic             ps_c, is_c, fl_c, ib_c;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .clr_i (rst | cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_set = 1'b0;
        ps_c        = 1'b0;
        is_c        = 1'b0;
        fl_c        = 1'b0;
        ib_c        = 1'b0;

        unique case (state_q)
            RUN: begin
                if (hlt) begin
                    {ps_c, is_c, ib_c} = 3'b111;
                    state_d = HALT;
                    cnt_clr = 1'b1;
                end else if (PC_update) begin
                    // stray target update outside PC_WAIT: nothing to release
                    state_d = RUN;
                end else if (PC_hazard) begin
                    ps_c    = 1'b1;
                    fl_c    = 1'b1;
                    state_d = PC_WAIT;
                end else if (branch_taken) begin
                    fl_c = 1'b1;
                    ib_c = 1'b1;
                    if (BR_FLUSH_CYC > 1) begin
                        state_d = BR_FLUSH;
                        cnt_inc = 1'b1;
                    end
                end else if (data_hazard) begin
                    {ps_c, is_c, ib_c} = 3'b111;
                    state_d = DSTALL;
                    cnt_inc = 1'b1;
                end
            end

            DSTALL: begin
                if (hlt) begin
                    {ps_c, is_c, ib_c} = 3'b111;
                    state_d = HALT;
                    cnt_clr = 1'b1;
                end else if (data_hazard && (cnt_q < CNT_W'(MAX_STALL))) begin
                    {ps_c, is_c, ib_c} = 3'b111;
                    cnt_inc = 1'b1;
                end else begin
                    // forced release when the hazard outlives MAX_STALL
                    timeout_set = data_hazard;
                    state_d     = RUN;
                    cnt_clr     = 1'b1;
                end
            end

            PC_WAIT: begin
                if (hlt) begin
                    {ps_c, is_c, ib_c} = 3'b111;
                    state_d = HALT;
                    cnt_clr = 1'b1;
                end else begin
                    fl_c = 1'b1;
                    ib_c = 1'b1;
                    if (PC_update) begin
                        state_d = RUN;
                        cnt_clr = 1'b1;
                    end else begin
                        ps_c = 1'b1;
                    end
                end
            end

            BR_FLUSH: begin
                if (hlt) begin
                    {ps_c, is_c, ib_c} = 3'b111;
                    state_d = HALT;
                    cnt_clr = 1'b1;
                end else begin
                    fl_c = 1'b1;
                    ib_c = 1'b1;
                    if (cnt_q == CNT_W'(BR_FLUSH_CYC - 1)) begin
                        state_d = RUN;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            HALT: begin
                {ps_c, is_c, ib_c} = 3'b111;
            end

            default: begin
                state_d = RUN;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // During reset everything reads as RUN with inputs ignored.
    assign PC_stall      = ~rst & ps_c;
    assign IFID_stall    = ~rst & is_c;
    assign IFID_flush    = ~rst & fl_c;
    assign IDEX_bubble   = ~rst & ib_c;
    assign halted        = ~rst & (state_q == HALT);
    assign stall_timeout = ~rst & timeout_q;
    assign state_dbg     = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one instance with two-cycle branch
// flush and one with default parameters, driven from shared inputs.
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst, data_hazard, PC_hazard, PC_update, branch_taken, hlt;
    logic ps2, is2, fl2, ib2, hl2, to2;
    logic ps1, is1, fl1, ib1, hl1, to1;
    logic [2:0] st2, st1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string      tag;
        logic [8:0] exp2;
        logic [8:0] exp1;
    } exp_t;
    exp_t sb_q[$];

    pipe_stall_ctrl #(.MAX_STALL(3), .BR_FLUSH_CYC(2), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .data_hazard(data_hazard), .PC_hazard(PC_hazard),
        .PC_update(PC_update), .branch_taken(branch_taken), .hlt(hlt),
        .PC_stall(ps2), .IFID_stall(is2), .IFID_flush(fl2), .IDEX_bubble(ib2),
        .halted(hl2), .stall_timeout(to2), .state_dbg(st2)
    );

    pipe_stall_ctrl u_br1 (
        .clk(clk), .rst(rst), .data_hazard(data_hazard), .PC_hazard(PC_hazard),
        .PC_update(PC_update), .branch_taken(branch_taken), .hlt(hlt),
        .PC_stall(ps1), .IFID_stall(is1), .IFID_flush(fl1), .IDEX_bubble(ib1),
        .halted(hl1), .stall_timeout(to1), .state_dbg(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] o(input logic ps, is, fl, ib, hl, to,
                                     input logic [2:0] st);
        return {ps, is, fl, ib, hl, to, st};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, queue expectations, compare mid-cycle.
    task automatic step(input string tag, input logic r, dh, ph, pu, bt, h,
                        input logic [8:0] e2, input logic [8:0] e1);
        exp_t cur;
        rst = r; data_hazard = dh; PC_hazard = ph;
        PC_update = pu; branch_taken = bt; hlt = h;
        sb_q.push_back('{tag, e2, e1});
        @(negedge clk);
        cur = sb_q.pop_front();
        check({cur.tag, "/br2"}, {ps2, is2, fl2, ib2, hl2, to2, st2}, cur.exp2);
        check({cur.tag, "/br1"}, {ps1, is1, fl1, ib1, hl1, to1, st1}, cur.exp1);
        n_checks++;
        assert (!(is2 && fl2) && !(is1 && fl1)) else begin
            n_err++;
            $error("FAIL %s/stall_flush_excl observed=%b%b%b%b expected=no overlap",
                   cur.tag, is2, fl2, is1, fl1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] z, tr;
        z  = o(0,0,0,0,0,0,3'd0);
        tr = o(1,1,0,1,0,0,3'd0);

        rst = 1; data_hazard = 1; PC_hazard = 0; PC_update = 0;
        branch_taken = 0; hlt = 1;
        @(posedge clk);
        #1;

        //             tag          rst dh  ph pu bt h
        step("rst_c1",      1, 1, 0, 0, 0, 1, z, z);
        step("rst_c2",      1, 1, 0, 0, 0, 1, z, z);
        step("rel_stall",   0, 1, 0, 0, 0, 0, tr, tr);
        step("dstall_c2",   0, 1, 0, 0, 0, 0, o(1,1,0,1,0,0,3'd1), o(1,1,0,1,0,0,3'd1));
        step("dstall_rel",  0, 0, 0, 0, 0, 0, o(0,0,0,0,0,0,3'd1), o(0,0,0,0,0,0,3'd1));
        step("dh_x",        0, 1'bx, 0, 0, 0, 0, z, z);

        step("to_c1",       0, 1, 0, 0, 0, 0, tr, tr);
        step("to_c2",       0, 1, 0, 0, 0, 0, o(1,1,0,1,0,0,3'd1), o(1,1,0,1,0,0,3'd1));
        step("to_c3",       0, 1, 0, 0, 0, 0, o(1,1,0,1,0,0,3'd1), o(1,1,0,1,0,0,3'd1));
        step("to_c4",       0, 1, 0, 0, 0, 0, o(0,0,0,0,0,0,3'd1), o(0,0,0,0,0,0,3'd1));
        step("to_c5",       0, 1, 0, 0, 0, 0, o(1,1,0,1,0,1,3'd0), o(1,1,0,1,0,1,3'd0));
        step("to_c6",       0, 0, 0, 0, 0, 0, o(0,0,0,0,0,1,3'd1), o(0,0,0,0,0,1,3'd1));
        step("to_idle",     0, 0, 0, 0, 0, 0, o(0,0,0,0,0,1,3'd0), o(0,0,0,0,0,1,3'd0));

        step("ret_c1",      0, 0, 1, 0, 0, 0, o(1,0,1,0,0,1,3'd0), o(1,0,1,0,0,1,3'd0));
        step("ret_c2",      0, 0, 1, 0, 0, 0, o(1,0,1,1,0,1,3'd2), o(1,0,1,1,0,1,3'd2));
        step("ret_c3",      0, 1, 1, 0, 0, 0, o(1,0,1,1,0,1,3'd2), o(1,0,1,1,0,1,3'd2));
        step("ret_c4",      0, 0, 1, 0, 0, 0, o(1,0,1,1,0,1,3'd2), o(1,0,1,1,0,1,3'd2));
        step("ret_upd",     0, 0, 0, 1, 0, 0, o(0,0,1,1,0,1,3'd2), o(0,0,1,1,0,1,3'd2));
        step("ret_idle",    0, 0, 0, 0, 0, 0, o(0,0,0,0,0,1,3'd0), o(0,0,0,0,0,1,3'd0));

        step("br_c1",       0, 0, 0, 0, 1, 0, o(0,0,1,1,0,1,3'd0), o(0,0,1,1,0,1,3'd0));
        step("br_c2",       0, 0, 0, 0, 0, 0, o(0,0,1,1,0,1,3'd3), o(0,0,0,0,0,1,3'd0));
        step("br_idle",     0, 0, 0, 0, 0, 0, o(0,0,0,0,0,1,3'd0), o(0,0,0,0,0,1,3'd0));
        step("br_dh_c1",    0, 1, 0, 0, 1, 0, o(0,0,1,1,0,1,3'd0), o(0,0,1,1,0,1,3'd0));
        step("br_dh_c2",    0, 0, 0, 0, 0, 0, o(0,0,1,1,0,1,3'd3), o(0,0,0,0,0,1,3'd0));

        step("pri_hlt",     0, 1, 0, 0, 1, 1, o(1,1,0,1,0,1,3'd0), o(1,1,0,1,0,1,3'd0));
        step("halt_pu",     0, 0, 0, 1, 0, 0, o(1,1,0,1,1,1,3'd4), o(1,1,0,1,1,1,3'd4));
        step("halt_mix",    0, 1, 1, 1, 1, 0, o(1,1,0,1,1,1,3'd4), o(1,1,0,1,1,1,3'd4));
        step("halt_rst",    1, 0, 0, 0, 0, 1, z, z);
        step("post_rst",    0, 0, 0, 0, 0, 0, z, z);

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
